// File: rtl/td4_pkg.sv
// Shared constants for the TD4 sequencing decoder: opcodes, source-mux codes,
// load-enable bit positions and FSM state encodings.
package td4_pkg;

    localparam logic [3:0] OP_ADD_A_IM = 4'b0000;
    localparam logic [3:0] OP_MOV_A_B  = 4'b0001;
    localparam logic [3:0] OP_IN_A     = 4'b0010;
    localparam logic [3:0] OP_MOV_A_IM = 4'b0011;
    localparam logic [3:0] OP_MOV_B_A  = 4'b0100;
    localparam logic [3:0] OP_ADD_B_IM = 4'b0101;
    localparam logic [3:0] OP_IN_B     = 4'b0110;
    localparam logic [3:0] OP_MOV_B_IM = 4'b0111;
    localparam logic [3:0] OP_HALT     = 4'b1000;
    localparam logic [3:0] OP_OUT_B    = 4'b1001;
    localparam logic [3:0] OP_OUT_IM   = 4'b1011;
    localparam logic [3:0] OP_JNC      = 4'b1110;
    localparam logic [3:0] OP_JMP      = 4'b1111;

    localparam logic [1:0] SEL_A    = 2'b00;
    localparam logic [1:0] SEL_B    = 2'b01;
    localparam logic [1:0] SEL_IN   = 2'b10;
    localparam logic [1:0] SEL_ZERO = 2'b11;

    localparam logic [1:0] LD_A   = 2'd3;
    localparam logic [1:0] LD_B   = 2'd2;
    localparam logic [1:0] LD_OUT = 2'd1;
    localparam logic [1:0] LD_PC  = 2'd0;

    localparam logic [3:0] LOAD_NONE = 4'b1111;

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    typedef enum logic [1:0] {
        S_FETCH = ST_FETCH,
        S_EXEC  = ST_EXEC,
        S_HALT  = ST_HALT
    } state_e;

    // Active-low enable word with only the addressed register loading.
    function automatic logic [3:0] load_only(input logic [1:0] idx);
        logic [3:0] m;
        m      = LOAD_NONE;
        m[idx] = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/td4_op_decode.sv
// Combinational opcode table: maps the captured opcode and carry flag to the
// source-mux select and active-low load enables.
module td4_op_decode
    import td4_pkg::*;
#(
    parameter bit HALT_EN = 1'b1
) (
    input  logic [3:0] op_i,
    input  logic       cflg_i,
    output logic [1:0] select_o,
    output logic [3:0] load_n_o,
    output logic       is_add_o,
    output logic       is_halt_o
);

    always_comb begin
        select_o  = SEL_ZERO;
        load_n_o  = LOAD_NONE;
        is_add_o  = 1'b0;
        is_halt_o = 1'b0;
        case (op_i)
            OP_ADD_A_IM: begin
                select_o = SEL_A;
                load_n_o = load_only(LD_A);
                is_add_o = 1'b1;
            end
            OP_MOV_A_B: begin
                select_o = SEL_B;
                load_n_o = load_only(LD_A);
            end
            OP_IN_A: begin
                select_o = SEL_IN;
                load_n_o = load_only(LD_A);
            end
            OP_MOV_A_IM: begin
                select_o = SEL_ZERO;
                load_n_o = load_only(LD_A);
            end
            OP_MOV_B_A: begin
                select_o = SEL_A;
                load_n_o = load_only(LD_B);
            end
            OP_ADD_B_IM: begin
                select_o = SEL_B;
                load_n_o = load_only(LD_B);
                is_add_o = 1'b1;
            end
            OP_IN_B: begin
                select_o = SEL_IN;
                load_n_o = load_only(LD_B);
            end
            OP_MOV_B_IM: begin
                select_o = SEL_ZERO;
                load_n_o = load_only(LD_B);
            end
            OP_OUT_B: begin
                select_o = SEL_B;
                load_n_o = load_only(LD_OUT);
            end
            OP_OUT_IM: begin
                select_o = SEL_ZERO;
                load_n_o = load_only(LD_OUT);
            end
            OP_JMP: begin
                select_o = SEL_ZERO;
                load_n_o = load_only(LD_PC);
            end
            // Jump is taken only when the previous instruction left no carry.
            OP_JNC: begin
                select_o = SEL_ZERO;
                if (!cflg_i) begin
                    load_n_o = load_only(LD_PC);
                end
            end
            OP_HALT: begin
                is_halt_o = HALT_EN;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/td4_seq_decoder.sv
// TD4 instruction sequencer: FETCH/EXEC/HALT FSM with instruction capture,
// a registered carry flag and a one-cycle decoded control strobe.
module td4_seq_decoder
    import td4_pkg::*;
#(
    parameter int unsigned DATA_W  = 4,
    parameter bit          HALT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        instr_op,
    input  logic [DATA_W-1:0] instr_imm,
    input  logic              alu_carry,
    output logic [1:0]        select,
    output logic [3:0]        load_n,
    output logic [DATA_W-1:0] imm,
    output logic              exec,
    output logic              cflg,
    output logic              halted
);

    state_e            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic              cflg_q, cflg_d;

    logic [1:0] dec_select;
    logic [3:0] dec_load_n;
    logic       dec_is_add;
    logic       dec_is_halt;
    logic       handshake;

    td4_op_decode #(
        .HALT_EN (HALT_EN)
    ) u_op_decode (
        .op_i      (op_q),
        .cflg_i    (cflg_q),
        .select_o  (dec_select),
        .load_n_o  (dec_load_n),
        .is_add_o  (dec_is_add),
        .is_halt_o (dec_is_halt)
    );

    assign instr_ready = (state_q == S_FETCH);
    assign handshake   = instr_valid & instr_ready;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        imm_d   = imm_q;
        cflg_d  = cflg_q;
        case (state_q)
            S_FETCH: begin
                if (handshake) begin
                    op_d    = instr_op;
                    imm_d   = instr_imm;
                    state_d = S_EXEC;
                end
            end
            // HALT keeps the flag; every other executed opcode rewrites it.
            S_EXEC: begin
                if (dec_is_halt) begin
                    state_d = S_HALT;
                end else begin
                    cflg_d  = dec_is_add ? alu_carry : 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            imm_q   <= '0;
            cflg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            imm_q   <= imm_d;
            cflg_q  <= cflg_d;
        end
    end

    assign exec   = (state_q == S_EXEC);
    assign halted = (state_q == S_HALT);
    assign select = exec ? dec_select : SEL_ZERO;
    assign load_n = exec ? dec_load_n : LOAD_NONE;
    assign imm    = imm_q;
    assign cflg   = cflg_q;

endmodule
